// File: rtl/cube_arbiter.sv
// Round-robin sequencer sharing one cube unit among N requesters; ack one cycle after a request is seen in IDLE.
// Done follows START_CYC + cube busy + 2 cycles later. Requesters hold req until ack, and only one operation is in flight.
module cube_arbiter #(
    parameter int N         = 4,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic [8*N-1:0] x_bi,
    output logic [N-1:0]   ack_o,
    output logic [N-1:0]   done_o,
    output logic           err_o,
    output logic [23:0]    y_bo,
    output logic           busy_o,
    output logic           cube_start_o,
    output logic [7:0]     cube_x_bo,
    input  logic [1:0]     cube_busy_i,
    input  logic [23:0]    cube_y_bi
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt;
    logic [IW-1:0] sel;
    logic          sel_vld;
    logic [IW:0]   rr_idx;
    logic [3:0]    scnt;
    logic [TW-1:0] tcnt;
    logic [7:0]    x_arr [N];
    logic [N-1:0]  sel_onehot;
    logic [N-1:0]  gnt_onehot;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign x_arr[k] = x_bi[8*k +: 8];
    end

    // First set request at or after the pointer, scanning with wrap-around.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        rr_idx  = '0;
        for (int i = 0; i < N; i++) begin
            rr_idx = {1'b0, ptr} + (IW+1)'(i);
            if (rr_idx >= (IW+1)'(N)) begin
                rr_idx = rr_idx - (IW+1)'(N);
            end
            if (!sel_vld && req_i[rr_idx[IW-1:0]]) begin
                sel_vld = 1'b1;
                sel     = rr_idx[IW-1:0];
            end
        end
    end

    assign sel_onehot = N'(1) << sel;
    assign gnt_onehot = N'(1) << gnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            scnt         <= '0;
            tcnt         <= '0;
            ack_o        <= '0;
            done_o       <= '0;
            err_o        <= 1'b0;
            y_bo         <= '0;
            busy_o       <= 1'b0;
            cube_start_o <= 1'b0;
            cube_x_bo    <= '0;
        end else begin
            ack_o  <= '0;
            done_o <= '0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        ack_o        <= sel_onehot;
                        gnt          <= sel;
                        cube_x_bo    <= x_arr[sel];
                        ptr          <= (sel == IW'(N-1)) ? '0 : sel + 1'b1;
                        scnt         <= '0;
                        cube_start_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    if (scnt == 4'(START_CYC-1)) begin
                        cube_start_o <= 1'b0;
                        tcnt         <= '0;
                        state        <= WAIT_BUSY;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (cube_busy_i != 2'b00) begin
                        tcnt  <= '0;
                        state <= WAIT_DONE;
                    end else if (tcnt == TW'(TIMEOUT-1)) begin
                        y_bo   <= '0;
                        err_o  <= 1'b1;
                        done_o <= gnt_onehot;
                        state  <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (cube_busy_i == 2'b00) begin
                        y_bo   <= cube_y_bi;
                        done_o <= gnt_onehot;
                        state  <= RESP;
                    end else if (tcnt == TW'(TIMEOUT-1)) begin
                        y_bo   <= '0;
                        err_o  <= 1'b1;
                        done_o <= gnt_onehot;
                        state  <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o       <= 1'b0;
                    cube_start_o <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cube_arbiter.sv
// Randomised and directed bench for cube_arbiter against a queue-based round-robin model and a behavioural cube.
module tb_cube_arbiter;
    localparam int N  = 4;
    localparam int SC = 2;
    localparam int TO = 64;
    localparam int WD_LIM = 2 * TO + SC + 60;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_i;
    wire  [8*N-1:0] x_bi;
    logic [N-1:0]   ack_o;
    logic [N-1:0]   done_o;
    logic           err_o;
    logic [23:0]    y_bo;
    logic           busy_o;
    logic           cube_start_o;
    logic [7:0]     cube_x_bo;
    logic [1:0]     cube_busy_i;
    logic [23:0]    cube_y_bi;
    logic [7:0]     xs [N];

    for (genvar k = 0; k < N; k++) begin : g_x
        assign x_bi[8*k +: 8] = xs[k];
    end

    cube_arbiter #(.N(N), .START_CYC(SC), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .x_bi(x_bi),
        .ack_o(ack_o), .done_o(done_o), .err_o(err_o), .y_bo(y_bo),
        .busy_o(busy_o), .cube_start_o(cube_start_o), .cube_x_bo(cube_x_bo),
        .cube_busy_i(cube_busy_i), .cube_y_bi(cube_y_bi)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Cube stand-in: 0 = normal, 1 = never raises busy, 2 = busy far beyond the timeout.
    int          cube_mode = 0;
    int          cube_len = 0;
    int          cb_cnt;
    logic        cb_armed;
    logic [23:0] cb_res;

    always @(negedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cb_cnt      = 0;
            cb_armed    = 1'b1;
            cube_busy_i = 2'b00;
            cube_y_bi   = 24'h0;
        end else begin
            if (cb_cnt > 0) begin
                cb_cnt--;
                if (cb_cnt == 0) begin
                    cube_busy_i = 2'b00;
                    cube_y_bi   = cb_res;
                end
            end else if (cube_start_o && cb_armed && cube_mode != 1) begin
                cb_res      = 24'(cube_x_bo) * 24'(cube_x_bo) * 24'(cube_x_bo);
                cube_busy_i = 2'($urandom_range(1, 3));
                cube_y_bi   = 24'($urandom);
                cb_armed    = 1'b0;
                if (cube_mode == 2)    cb_cnt = TO + 30;
                else if (cube_len > 0) cb_cnt = cube_len;
                else                   cb_cnt = SC + 1 + int'($urandom_range(0, 12));
            end
            if (!cube_start_o) cb_armed = 1'b1;
        end
    end

    // Reference model: pointer as an integer, in-flight expectation queue, observed done log.
    int   m_ptr = 0;
    logic m_idle = 1'b1;
    logic m_prev_done = 1'b0;
    int   q_g[$];
    int   q_y[$];
    int   q_e[$];
    int   log_g[$];
    int   log_y[$];
    int   log_e[$];
    int   wd = 0;
    int   cyc = 0;
    int   ack_cyc = 0;
    int   done_cyc = 0;
    int   req_cyc = 0;
    logic [N-1:0] hold = '0;

    task automatic observe();
        logic [N-1:0] exp_ack;
        int g;
        int dg;
        exp_ack = '0;
        if (m_idle) begin
            g = -1;
            for (int d = 0; d < N; d++)
                if (g < 0 && req_i[(m_ptr + d) % N]) g = (m_ptr + d) % N;
            if (g >= 0) begin
                exp_ack[g] = 1'b1;
                m_ptr = (g + 1) % N;
                q_g.push_back(g);
                if (cube_mode == 0) begin
                    q_y.push_back(int'(xs[g]) * int'(xs[g]) * int'(xs[g]));
                    q_e.push_back(0);
                end else begin
                    q_y.push_back(0);
                    q_e.push_back(1);
                end
                m_idle  = 1'b0;
                ack_cyc = cyc;
            end
        end else if (m_prev_done) begin
            m_idle = 1'b1;
        end
        check("ack", 32'(ack_o), 32'(exp_ack));
        check("busy", 32'(busy_o), 32'(!m_idle));
        if (done_o != '0) begin
            dg = -1;
            for (int k = 0; k < N; k++) if (done_o[k] && dg < 0) dg = k;
            log_g.push_back(dg);
            log_y.push_back(int'(y_bo));
            log_e.push_back(int'(err_o));
            if (q_g.size() == 0) begin
                check("done_unexpected", 32'(done_o), 32'(0));
            end else begin
                g = q_g.pop_front();
                check("done_vec", 32'(done_o), 32'(1) << g);
                check("y", 32'(y_bo), q_y.pop_front());
                check("err", 32'(err_o), q_e.pop_front());
            end
            done_cyc    = cyc;
            wd          = 0;
            m_prev_done = 1'b1;
        end else begin
            m_prev_done = 1'b0;
        end
        if (q_g.size() > 0) begin
            wd++;
            if (wd == WD_LIM) check("op_timeout", 32'(q_g.size()), 32'(0));
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        cyc++;
        observe();
        for (int k = 0; k < N; k++) if (ack_o[k] && !hold[k]) req_i[k] = 1'b0;
    endtask

    task automatic model_reset();
        req_i = '0;
        hold  = '0;
        m_ptr = 0;
        m_idle = 1'b1;
        m_prev_done = 1'b0;
        wd = 0;
        q_g.delete();
        q_y.delete();
        q_e.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic log_clear();
        log_g.delete();
        log_y.delete();
        log_e.delete();
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while ((req_i != '0 || q_g.size() != 0 || !m_idle) && n < budget) begin
            step();
            n++;
        end
        check("drain", 32'(q_g.size()) + 32'(!m_idle), 32'(0));
    endtask

    task automatic wait_log(input int cnt, input int budget);
        int n;
        n = 0;
        while (log_g.size() < cnt && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic check_log(input string tag, input int i, input int g, input int y, input int e);
        if (i < log_g.size()) begin
            check({tag, "_grant"}, log_g[i], g);
            check({tag, "_y"}, log_y[i], y);
            check({tag, "_err"}, log_e[i], e);
        end else begin
            check({tag, "_count"}, log_g.size(), i + 1);
        end
    endtask

    initial begin
        int n;
        int start_hi;
        rst_i = 1'b0;
        req_i = '0;
        for (int k = 0; k < N; k++) xs[k] = 8'h0;
        #1;
        check("rst_ack", 32'(ack_o), 32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_err", 32'(err_o), 32'(0));
        check("rst_y", 32'(y_bo), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_start", 32'(cube_start_o), 32'(0));
        check("rst_x", 32'(cube_x_bo), 32'(0));
        do_reset();

        // Single request, cube busy 10 cycles starting in the first start cycle.
        cube_len = 10;
        log_clear();
        xs[0] = 8'd5;
        req_i = 4'b0001;
        req_cyc = cyc;
        start_hi = 0;
        n = 0;
        while (log_g.size() == 0 && n < 300) begin
            step();
            if (cube_start_o) start_hi++;
            n++;
        end
        check("t1_ack_lat", ack_cyc - req_cyc, 1);
        check("t1_start_len", start_hi, SC);
        check("t1_latency", done_cyc - ack_cyc, cube_len + 1);
        check_log("t1", 0, 0, 125, 0);
        wait_all(100);

        // All four at once from a reset pointer.
        cube_len = 0;
        do_reset();
        log_clear();
        xs[0] = 8'd1; xs[1] = 8'd13; xs[2] = 8'd25; xs[3] = 8'd37;
        req_i = 4'b1111;
        wait_all(2000);
        check_log("all0", 0, 0, 1, 0);
        check_log("all1", 1, 1, 2197, 0);
        check_log("all2", 2, 2, 15625, 0);
        check_log("all3", 3, 3, 50653, 0);

        // Fairness with requesters 0 and 2 held continuously.
        do_reset();
        log_clear();
        xs[0] = 8'd3; xs[2] = 8'd6;
        hold  = 4'b0101;
        req_i = 4'b0101;
        wait_log(6, 3000);
        hold  = '0;
        req_i = '0;
        wait_all(500);
        for (int i = 0; i < 6; i++)
            check_log("fair", i, (i % 2 == 0) ? 0 : 2, (i % 2 == 0) ? 27 : 216, 0);

        // Cube never raises busy: timeout in WAIT_BUSY, then a normal operation.
        cube_mode = 1;
        log_clear();
        xs[1] = 8'd7;
        req_i = 4'b0010;
        wait_log(1, 500);
        check("to1_latency", done_cyc - ack_cyc, SC + TO);
        check_log("to1", 0, 1, 0, 1);
        wait_all(100);
        cube_mode = 0;
        log_clear();
        xs[1] = 8'd9;
        req_i = 4'b0010;
        wait_all(500);
        check_log("after_to", 0, 1, 729, 0);

        // Cube stays busy past the timeout: abort from WAIT_DONE.
        cube_mode = 2;
        log_clear();
        xs[3] = 8'd11;
        req_i = 4'b1000;
        wait_log(1, 500);
        check("to2_latency", done_cyc - ack_cyc, SC + TO + 1);
        check_log("to2", 0, 3, 0, 1);
        cube_mode = 0;
        repeat (40) step();

        // Operand extremes.
        log_clear();
        xs[0] = 8'd0; xs[1] = 8'd255;
        req_i = 4'b0011;
        wait_all(1000);
        check_log("xmin", 0, 0, 0, 0);
        check_log("xmax", 1, 1, 16581375, 0);

        // Reset in WAIT_DONE clears outputs immediately and restores the pointer.
        cube_len = 30;
        xs[1] = 8'd77;
        req_i = 4'b0010;
        n = 0;
        while (ack_o == '0 && n < 50) begin
            step();
            n++;
        end
        repeat (SC + 3) step();
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o), 32'(0));
        check("arst_start", 32'(cube_start_o), 32'(0));
        check("arst_y", 32'(y_bo), 32'(0));
        check("arst_x", 32'(cube_x_bo), 32'(0));
        check("arst_done", 32'(done_o), 32'(0));
        model_reset();
        @(posedge clk_i);
        #1;
        check("arst_done_hold", 32'(done_o), 32'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        cube_len = 0;
        log_clear();
        xs[0] = 8'd4; xs[3] = 8'd5;
        req_i = 4'b1001;
        wait_all(1000);
        check_log("post_rst0", 0, 0, 64, 0);
        check_log("post_rst1", 1, 3, 125, 0);

        // Random traffic: random raises, withdrawals before ack, re-requests and operand churn.
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (ack_o[k]) xs[k] = 8'($urandom);
                if (!req_i[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_i[k] = 1'b1;
                        xs[k] = 8'($urandom);
                    end
                end else if (!ack_o[k] && $urandom_range(0, 15) == 0) begin
                    req_i[k] = 1'b0;
                end
            end
        end
        req_i = '0;
        wait_all(1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks made", n_chk);
        $fatal(1, "global timeout");
    end
endmodule
